// File: rtl/uart_bram_traffic_controller.sv
// UART-to-BRAM traffic controller: stores a byte stream on WRITE, replays it on READ.
// Optional macro UBTC_ERASE_EN adds the ERASE command that zero-fills the whole BRAM.
module uart_bram_traffic_controller #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int SIZE       = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rx_done,
    input  logic                  tx_busy,
    input  logic [DATA_WIDTH-1:0] from_BRAM,
    output logic                  en,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] to_BRAM,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam logic [DATA_WIDTH-1:0] CMD_READ  = DATA_WIDTH'(8'h11);
    localparam logic [DATA_WIDTH-1:0] CMD_WRITE = DATA_WIDTH'(8'h12);
`ifdef UBTC_ERASE_EN
    localparam logic [DATA_WIDTH-1:0] CMD_ERASE = DATA_WIDTH'(8'h13);
`endif
    localparam logic [DATA_WIDTH-1:0] CMD_ESC   = DATA_WIDTH'(8'h1B);
    localparam logic [ADDR_WIDTH:0]   SIZE_W    = (ADDR_WIDTH+1)'(SIZE);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_REQ,
        READ_WAIT,
        SEND,
        SEND_WAIT
`ifdef UBTC_ERASE_EN
        , ERASE
`endif
    } state_t;

    state_t                state, state_next;
    logic                  rx_prev;
    logic                  rx_byte;
    logic [ADDR_WIDTH:0]   wp, wp_next;
    logic [ADDR_WIDTH:0]   rp, rp_next, rp_inc;
    logic [ADDR_WIDTH:0]   length, length_next;
    logic [1:0]            wait_cnt, wait_next;
    logic                  en_next, we_next, tx_start_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [DATA_WIDTH-1:0] to_bram_next, dout_next;

    assign rx_byte = rx_done & ~rx_prev;

    // During reset rx_prev follows rx_done so a level held across reset is not seen as a new byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rx_prev      <= rx_done;
            en           <= 1'b0;
            write_enable <= 1'b0;
            addr         <= '0;
            to_BRAM      <= '0;
            tx_start     <= 1'b0;
            dout         <= '0;
            wp           <= '0;
            rp           <= '0;
            length       <= '0;
            wait_cnt     <= '0;
        end else begin
            state        <= state_next;
            rx_prev      <= rx_done;
            en           <= en_next;
            write_enable <= we_next;
            addr         <= addr_next;
            to_BRAM      <= to_bram_next;
            tx_start     <= tx_start_next;
            dout         <= dout_next;
            wp           <= wp_next;
            rp           <= rp_next;
            length       <= length_next;
            wait_cnt     <= wait_next;
        end
    end

    // Outputs are computed one cycle ahead so the BRAM strobes are registered.
    always_comb begin
        state_next    = state;
        en_next       = 1'b0;
        we_next       = 1'b0;
        tx_start_next = 1'b0;
        addr_next     = addr;
        to_bram_next  = to_BRAM;
        dout_next     = dout;
        wp_next       = wp;
        rp_next       = rp;
        length_next   = length;
        wait_next     = wait_cnt;
        rp_inc        = rp + 1'b1;

        case (state)
            IDLE: begin
                if (rx_byte) begin
                    case (din)
                        CMD_WRITE: begin
                            state_next = WRITE;
                            wp_next    = '0;
                        end
                        CMD_READ: begin
                            if (length != '0) begin
                                state_next = READ_REQ;
                                rp_next    = '0;
                                en_next    = 1'b1;
                                addr_next  = '0;
                            end
                        end
`ifdef UBTC_ERASE_EN
                        CMD_ERASE: begin
                            state_next   = ERASE;
                            en_next      = 1'b1;
                            we_next      = 1'b1;
                            addr_next    = '0;
                            to_bram_next = '0;
                            wp_next      = (ADDR_WIDTH+1)'(1);
                            length_next  = '0;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            WRITE: begin
                if (rx_byte) begin
                    if (din == CMD_ESC) begin
                        length_next = wp;
                        state_next  = IDLE;
                    end else if (wp != SIZE_W) begin
                        en_next      = 1'b1;
                        we_next      = 1'b1;
                        addr_next    = wp[ADDR_WIDTH-1:0];
                        to_bram_next = din;
                        wp_next      = wp + 1'b1;
                    end
                end
            end
            READ_REQ: begin
                state_next = READ_WAIT;
            end
            READ_WAIT: begin
                dout_next  = from_BRAM;
                state_next = SEND;
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_start_next = 1'b1;
                    wait_next     = '0;
                    state_next    = SEND_WAIT;
                end
            end
            SEND_WAIT: begin
                // The UART may take a couple of cycles to raise tx_busy after tx_start.
                if (wait_cnt != 2'd2) begin
                    wait_next = wait_cnt + 1'b1;
                end else if (!tx_busy) begin
                    rp_next = rp_inc;
                    if (rp_inc == length) begin
                        state_next = IDLE;
                    end else begin
                        state_next = READ_REQ;
                        en_next    = 1'b1;
                        addr_next  = rp_inc[ADDR_WIDTH-1:0];
                    end
                end
            end
`ifdef UBTC_ERASE_EN
            ERASE: begin
                if (wp == SIZE_W) begin
                    state_next = IDLE;
                end else begin
                    en_next      = 1'b1;
                    we_next      = 1'b1;
                    addr_next    = wp[ADDR_WIDTH-1:0];
                    to_bram_next = '0;
                    wp_next      = wp + 1'b1;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_bram_traffic_controller.sv
// Directed bench for uart_bram_traffic_controller with a BRAM model and a UART TX busy model.
// Honours UBTC_ERASE_EN to select the expected ERASE behaviour.
module tb_uart_bram_traffic_controller;

    localparam int DW = 8;
    localparam int AW = 12;
    localparam int SZ = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din;
    logic          rx_done;
    logic          tx_busy;
    logic [DW-1:0] from_BRAM;
    logic          en;
    logic          write_enable;
    logic [AW-1:0] addr;
    logic [DW-1:0] to_BRAM;
    logic          tx_start;
    logic [DW-1:0] dout;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mem [0:SZ-1];
    int            wr_addr [$];
    int            wr_data [$];
    int            tx_log  [$];
    int            en_cnt;
    int            busy_viol;
    int            busy_cnt;

    uart_bram_traffic_controller #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .SIZE       (SZ)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .rx_done      (rx_done),
        .tx_busy      (tx_busy),
        .from_BRAM    (from_BRAM),
        .en           (en),
        .write_enable (write_enable),
        .addr         (addr),
        .to_BRAM      (to_BRAM),
        .tx_start     (tx_start),
        .dout         (dout)
    );

    always #5 clk = ~clk;

    // Synchronous BRAM with one cycle of read latency.
    always @(posedge clk) begin
        if (en) begin
            if (write_enable) mem[addr[1:0]] <= to_BRAM;
            else              from_BRAM <= mem[addr[1:0]];
        end
    end

    // Observe strobes and model the UART TX staying busy for 20 cycles after each start.
    always @(negedge clk) begin
        if (en && write_enable) begin
            wr_addr.push_back(int'(addr));
            wr_data.push_back(int'(to_BRAM));
        end
        if (en) en_cnt++;
        if (tx_start) begin
            if (tx_busy) busy_viol++;
            tx_log.push_back(int'(dout));
            busy_cnt = 20;
            tx_busy  = 1'b1;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [DW-1:0] b);
        @(negedge clk);
        din     = b;
        rx_done = 1'b1;
        repeat (50) @(negedge clk);
        rx_done = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic clearLogs();
        wr_addr.delete();
        wr_data.delete();
        tx_log.delete();
        en_cnt    = 0;
        busy_viol = 0;
    endtask

    task automatic waitTx(input int n);
        int t = 0;
        while (tx_log.size() < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        checkOutput("tx_wait_count", tx_log.size(), n);
    endtask

    task automatic checkWrites(input string tag, input int n, input logic [7:0] d0, input logic [7:0] step);
        logic [7:0] exp_d;
        checkOutput({tag, "_count"}, wr_addr.size(), n);
        exp_d = d0;
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, "_addr"}, wr_addr[i], i);
            checkOutput({tag, "_data"}, wr_data[i], exp_d);
            exp_d = exp_d + step;
        end
    endtask

    task automatic checkTx(input string tag, input int n, input logic [7:0] d0, input logic [7:0] step);
        logic [7:0] exp_d;
        exp_d = d0;
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, "_dout"}, tx_log[i], exp_d);
            exp_d = exp_d + step;
        end
        checkOutput({tag, "_busy_overlap"}, busy_viol, 0);
    endtask

    initial begin
        for (int i = 0; i < SZ; i++) mem[i] = 8'h00;
        rst       = 1'b1;
        din       = '0;
        rx_done   = 1'b0;
        tx_busy   = 1'b0;
        busy_cnt  = 0;
        from_BRAM = '0;
        clearLogs();
        repeat (3) @(negedge clk);
        checkOutput("reset_en", en, 0);
        checkOutput("reset_we", write_enable, 0);
        checkOutput("reset_addr", addr, 0);
        checkOutput("reset_to_bram", to_BRAM, 0);
        checkOutput("reset_tx_start", tx_start, 0);
        checkOutput("reset_dout", dout, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] empty read and unknown command");
        clearLogs();
        applyStimulus(8'h11);
        repeat (40) @(negedge clk);
        checkOutput("empty_read_tx", tx_log.size(), 0);
        checkOutput("empty_read_en", en_cnt, 0);
        applyStimulus(8'h55);
        repeat (20) @(negedge clk);
        checkOutput("unknown_en", en_cnt, 0);
        checkOutput("unknown_tx", tx_log.size(), 0);

        $display("[TB] write three bytes");
        clearLogs();
        applyStimulus(8'h12);
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        applyStimulus(8'hCC);
        applyStimulus(8'h1B);
        checkWrites("write3", 3, 8'hAA, 8'h11);

        $display("[TB] read back twice");
        for (int r = 0; r < 2; r++) begin
            clearLogs();
            applyStimulus(8'h11);
            waitTx(3);
            repeat (60) @(negedge clk);
            checkOutput("read_tx_total", tx_log.size(), 3);
            checkOutput("read_no_writes", wr_addr.size(), 0);
            checkTx("read", 3, 8'hAA, 8'h11);
        end

        $display("[TB] overflow write");
        clearLogs();
        applyStimulus(8'h12);
        for (int i = 1; i <= 6; i++) applyStimulus(8'(i));
        applyStimulus(8'h1B);
        checkWrites("overflow", 4, 8'h01, 8'h01);
        clearLogs();
        applyStimulus(8'h11);
        waitTx(4);
        repeat (60) @(negedge clk);
        checkOutput("overflow_tx_total", tx_log.size(), 4);
        checkTx("overflow_read", 4, 8'h01, 8'h01);

        $display("[TB] erase command");
        clearLogs();
        applyStimulus(8'h13);
        repeat (10) @(negedge clk);
`ifdef UBTC_ERASE_EN
        checkWrites("erase", SZ, 8'h00, 8'h00);
        clearLogs();
        applyStimulus(8'h11);
        repeat (60) @(negedge clk);
        checkOutput("erase_read_tx", tx_log.size(), 0);
        checkOutput("erase_read_en", en_cnt, 0);
`else
        checkOutput("erase_off_writes", wr_addr.size(), 0);
        checkOutput("erase_off_en", en_cnt, 0);
        clearLogs();
        applyStimulus(8'h11);
        waitTx(4);
        repeat (60) @(negedge clk);
        checkTx("erase_off_read", 4, 8'h01, 8'h01);
`endif

        $display("[TB] reset during transmit");
        clearLogs();
        applyStimulus(8'h12);
        applyStimulus(8'h5A);
        applyStimulus(8'h1B);
        checkWrites("single", 1, 8'h5A, 8'h00);
        @(negedge clk);
        din     = 8'h11;
        rx_done = 1'b1;
        waitTx(1);
        repeat (3) @(negedge clk);
        checkOutput("pre_reset_dout", dout, 8'h5A);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_en", en, 0);
        checkOutput("midrst_we", write_enable, 0);
        checkOutput("midrst_addr", addr, 0);
        checkOutput("midrst_to_bram", to_BRAM, 0);
        checkOutput("midrst_tx_start", tx_start, 0);
        checkOutput("midrst_dout", dout, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rx_done = 1'b0;
        repeat (30) @(negedge clk);
        clearLogs();
        applyStimulus(8'h11);
        repeat (60) @(negedge clk);
        checkOutput("post_reset_read_tx", tx_log.size(), 0);
        checkOutput("post_reset_read_en", en_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
